mux_scan_nto1: RTL and testbench

//  Parametrised, registered N-channel x W-bit multiplexer with two modes:
//  - Manual: a registered select input chooses the channel.
//  - Auto-scan: the block round-robins through the channels, holding each for a programmable dwell time.

---
 rtl/mux_scan_nto1.sv | 109 ++++++++++
 tb/tb_mux_scan_nto1.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-channel x W-bit multiplexer with manual select
// and an auto-scan mode that round-robins the channels with a programmable dwell.
//   clk, rst_n (sync, active-low), en (clock enable)
//   mode   : 0 = manual (ch follows s, clamped to N-1), 1 = auto-scan
//   s      : manual channel select
//   dwell  : auto mode holds each channel for dwell+1 enabled cycles
//   d      : flattened inputs, channel k = d[k*W +: W]
//   o      : registered data of the channel selected before the edge
//   ch     : current channel index, ch_onehot its decode
//   tick   : one-cycle pulse when ch advances in auto mode
module mux_scan_nto1 #(
  parameter int W       = 4,
  parameter int N       = 4,
  parameter int SW      = 2,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      s,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N*W-1:0]     d,
  output logic [W-1:0]       o,
  output logic [SW-1:0]      ch,
  output logic [N-1:0]       ch_onehot,
  output logic               tick
);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam logic [SW-1:0] CH_LAST = SW'(N - 1);

  mode_e              mode_q, mode_d;
  logic [SW-1:0]      ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       o_q, o_d;
  logic               tick_q, tick_d;
  logic [W-1:0]       sel_data;

  // Compare-based mux so an index never reaches past channel N-1.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ch_q == SW'(k)) begin
        sel_data = d[k*W +: W];
      end
    end
  end

  always_comb begin
    ch_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ch_q == SW'(k)) begin
        ch_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    o_d    = o_q;
    tick_d = 1'b0;
    if (en) begin
      o_d    = sel_data;
      mode_d = mode ? MODE_AUTO : MODE_MANUAL;
      if (!mode) begin
        ch_d  = (s > CH_LAST) ? CH_LAST : s;
        cnt_d = '0;
      end else if (mode_q == MODE_MANUAL) begin
        // First auto cycle: restart the dwell from the current channel.
        cnt_d = '0;
      end else if (cnt_q >= dwell) begin
        // >= lets a lowered dwell take effect without the counter overrunning.
        cnt_d  = '0;
        ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_MANUAL;
      ch_q   <= '0;
      cnt_q  <= '0;
      o_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      o_q    <= o_d;
      tick_q <= tick_d;
    end
  end

  assign o    = o_q;
  assign ch   = ch_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: a 4-channel and a 3-channel instance share
// clock, reset and enable; each has its own mode/select/dwell/data inputs.
module tb_mux_scan_nto1;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        mode, mode3;
  logic [1:0]  s, s3;
  logic [15:0] dwell, dwell3;
  logic [15:0] d;
  logic [11:0] d3;
  logic [3:0]  o, o3;
  logic [1:0]  ch, ch3;
  logic [3:0]  oh;
  logic [2:0]  oh3;
  logic        tick, tick3;

  int total = 0;
  int bad   = 0;

  // Auto scan with dwell=2 starting from ch=0; first entry is the entry cycle.
  logic [1:0] exp_ch [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic       exp_tk [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  always #5 clk = ~clk;

  mux_scan_nto1 #(.W(4), .N(4), .SW(2), .DWELL_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .dwell(dwell),
    .d(d), .o(o), .ch(ch), .ch_onehot(oh), .tick(tick)
  );

  mux_scan_nto1 #(.W(4), .N(3), .SW(2), .DWELL_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode3), .s(s3), .dwell(dwell3),
    .d(d3), .o(o3), .ch(ch3), .ch_onehot(oh3), .tick(tick3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; s = 2'd0; dwell = 16'd0; d = 16'hA5C3;
    mode3 = 1'b0; s3 = 2'd0; dwell3 = 16'd0; d3 = 12'hCBA;

    // Reset
    step(); step();
    check("rst_o", o, 0);
    check("rst_ch", ch, 0);
    check("rst_oh", oh, 4'b0001);
    check("rst_tick", tick, 0);
    check("rst_oh3", oh3, 3'b001);

    // Manual: o lags ch by one cycle
    rst_n = 1'b1;
    d = 16'h3210;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      step();
      check($sformatf("man_ch%0d", i), ch, i);
      check($sformatf("man_oh%0d", i), oh, 4'b0001 << i);
      check($sformatf("man_o%0d", i), o, (i == 0) ? 0 : i - 1);
      check($sformatf("man_tick%0d", i), tick, 0);
    end
    step();
    check("man_o_last", o, 3);

    // Auto, dwell=2, from ch=0
    s = 2'd0;
    step();
    check("pre_auto_ch", ch, 0);
    mode = 1'b1; dwell = 16'd2;
    for (int i = 0; i < 13; i++) begin
      step();
      check($sformatf("auto_ch%0d", i), ch, exp_ch[i]);
      check($sformatf("auto_tick%0d", i), tick, exp_tk[i]);
      check($sformatf("auto_o%0d", i), o, (i == 0) ? 0 : exp_ch[i-1]);
    end

    // en gating: dwell=1, freeze at ch=1 just after a tick
    dwell = 16'd1;
    step();
    check("eg_pre_ch0", ch, 0);
    step();
    check("eg_pre_ch1", ch, 1);
    check("eg_pre_tick", tick, 1);
    en = 1'b0; d = 16'hFFFF; s = 2'd3; dwell = 16'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("eg_ch%0d", i), ch, 1);
      check($sformatf("eg_tick%0d", i), tick, 0);
      check($sformatf("eg_o%0d", i), o, 0);
    end
    en = 1'b1; d = 16'h3210; dwell = 16'd1;
    step();
    check("eg_res_ch0", ch, 1);
    check("eg_res_o0", o, 1);
    check("eg_res_tick0", tick, 0);
    step();
    check("eg_res_ch1", ch, 2);
    check("eg_res_tick1", tick, 1);

    // N=3: manual clamp, then auto wrap 2->0
    s3 = 2'd3;
    step();
    check("n3_clamp_ch", ch3, 2);
    check("n3_clamp_oh", oh3, 3'b100);
    step();
    check("n3_clamp_o", o3, 4'hC);
    mode3 = 1'b1; dwell3 = 16'd0;
    step();
    check("n3_entry_ch", ch3, 2);
    check("n3_entry_tick", tick3, 0);
    step();
    check("n3_wrap_ch", ch3, 0);
    check("n3_wrap_tick", tick3, 1);
    step();
    check("n3_next_ch", ch3, 1);
    check("n3_next_o", o3, 4'hA);

    // Enter auto at ch=2 with dwell=3: held 4 cycles including entry
    mode = 1'b0; s = 2'd2;
    step();
    check("me_man_ch", ch, 2);
    mode = 1'b1; dwell = 16'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("me_hold_ch%0d", i), ch, 2);
      check($sformatf("me_hold_tick%0d", i), tick, 0);
    end
    step();
    check("me_adv_ch", ch, 3);
    check("me_adv_tick", tick, 1);

    // Lower dwell 10 -> 1 while cnt=5
    mode = 1'b0; s = 2'd0;
    step();
    mode = 1'b1; dwell = 16'd10;
    step();
    for (int i = 0; i < 5; i++) step();
    check("dw_pre_ch", ch, 0);
    dwell = 16'd1;
    step();
    check("dw_adv_ch", ch, 1);
    check("dw_adv_tick", tick, 1);

    // auto -> manual takes s immediately
    mode = 1'b0; s = 2'd3;
    step();
    check("am_ch", ch, 3);
    check("am_tick", tick, 0);

    // Reset mid-scan, then auto entry after reset does not advance
    mode = 1'b1; dwell = 16'd0;
    step(); step();
    check("rs_pre_ch", ch, 0);
    rst_n = 1'b0;
    step();
    check("rs_ch", ch, 0);
    check("rs_o", o, 0);
    check("rs_tick", tick, 0);
    rst_n = 1'b1;
    step();
    check("rs_entry_ch", ch, 0);
    check("rs_entry_tick", tick, 0);
    step();
    check("rs_adv_ch", ch, 1);
    check("rs_adv_tick", tick, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
